// File: rtl/hazard_ctrl.sv
// Hazard controller for the five-stage SCCPU: operand forwarding, load-use and MDU stalls,
// IF flush on taken control transfers, and busy tracking for the shared multi-cycle MDU.
module hazard_ctrl #(
    // Busy cycles after each MDU start; must lie in 1..255 to fit the 8-bit counter.
    parameter int unsigned MDU_LATENCY = 8
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_use_rs,
    input  logic        id_use_rt,
    input  logic [4:0]  id_rd,
    input  logic        id_wreg,
    input  logic        id_m2reg,
    input  logic        id_mdu,
    input  logic        id_mfhilo,
    input  logic        id_jump,
    output logic        stall,
    output logic        flush_if,
    output logic [1:0]  FwdA,
    output logic [1:0]  FwdB,
    output logic        mdu_start,
    output logic        mdu_busy,
    output logic [15:0] stall_count
);

    typedef enum logic [1:0] {
        FWD_RF       = 2'b00,
        FWD_EXE_ALU  = 2'b01,
        FWD_MEM_ALU  = 2'b10,
        FWD_MEM_LOAD = 2'b11
    } fwd_sel_e;

    // Destination record of an in-flight instruction; all-zero is a bubble.
    typedef struct packed {
        logic       wreg;
        logic       m2reg;
        logic [4:0] rd;
    } dst_t;

    localparam logic [7:0] MDU_CNT_LOAD = 8'(MDU_LATENCY);

    dst_t       id_dst;
    dst_t       ex_q;
    dst_t       mem_q;
    logic [7:0] mdu_cnt;
    logic       load_stall;
    logic       mdu_stall;
    logic       stall_raw;

    // EXE wins over MEM; a load still in EXE has no data yet, so it falls through to MEM.
    function automatic fwd_sel_e fwd_select(
        input logic       use_src,
        input logic [4:0] src,
        input dst_t       ex,
        input dst_t       mem
    );
        fwd_sel_e sel;
        sel = FWD_RF;
        if (use_src) begin
            if (ex.wreg && !ex.m2reg && ex.rd != 5'd0 && ex.rd == src) begin
                sel = FWD_EXE_ALU;
            end else if (mem.wreg && mem.rd != 5'd0 && mem.rd == src) begin
                sel = mem.m2reg ? FWD_MEM_LOAD : FWD_MEM_ALU;
            end
        end
        return sel;
    endfunction

    assign id_dst = '{wreg: id_wreg, m2reg: id_m2reg, rd: id_rd};

    assign load_stall = ex_q.wreg && ex_q.m2reg && (ex_q.rd != 5'd0) &&
                        ((id_use_rs && ex_q.rd == id_rs) || (id_use_rt && ex_q.rd == id_rt));
    assign mdu_stall  = mdu_busy && (id_mdu || id_mfhilo);
    assign stall_raw  = load_stall || mdu_stall;
    assign mdu_busy   = (mdu_cnt != 8'd0);

    always_comb begin
        // NOTE: every output gets a default before any branch so no path can infer a latch.
        stall     = 1'b0;
        flush_if  = 1'b0;
        mdu_start = 1'b0;
        FwdA      = FWD_RF;
        FwdB      = FWD_RF;
        if (!Reset) begin
            stall     = stall_raw;
            flush_if  = id_jump && !stall_raw;
            mdu_start = id_mdu && !stall_raw;
            FwdA      = fwd_select(id_use_rs, id_rs, ex_q, mem_q);
            FwdB      = fwd_select(id_use_rt, id_rt, ex_q, mem_q);
        end
    end

    always_ff @(posedge Clock) begin
        // NOTE: non-blocking assignments so each register samples pre-edge values of the others.
        if (Reset) begin
            ex_q        <= '0;
            mem_q       <= '0;
            mdu_cnt     <= '0;
            stall_count <= '0;
        end else begin
            mem_q <= ex_q;
            ex_q  <= stall ? dst_t'('0) : id_dst;

            if (mdu_start) begin
                mdu_cnt <= MDU_CNT_LOAD;
            end else if (mdu_cnt != 8'd0) begin
                mdu_cnt <= mdu_cnt - 8'd1;
            end

            if (stall && stall_count != 16'hFFFF) begin
                stall_count <= stall_count + 16'd1;
            end
        end
    end

    a_start_sets_busy: assert property (@(posedge Clock) disable iff (Reset)
        mdu_start |=> mdu_busy);
    a_stall_blocks_issue: assert property (@(posedge Clock) disable iff (Reset)
        stall |-> (!mdu_start && !flush_if));

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios followed by random instruction streams,
// all compared against a reference model of in-flight writers and the MDU ready time.
module tb_hazard_ctrl;

    localparam int LAT = 8;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic [4:0]  id_rs = '0, id_rt = '0, id_rd = '0;
    logic        id_use_rs = 1'b0, id_use_rt = 1'b0, id_wreg = 1'b0, id_m2reg = 1'b0;
    logic        id_mdu = 1'b0, id_mfhilo = 1'b0, id_jump = 1'b0;
    logic        stall, flush_if, mdu_start, mdu_busy;
    logic [1:0]  FwdA, FwdB;
    logic [15:0] stall_count;

    hazard_ctrl #(.MDU_LATENCY(LAT)) dut (
        .Clock(Clock), .Reset(Reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_rd(id_rd), .id_wreg(id_wreg), .id_m2reg(id_m2reg),
        .id_mdu(id_mdu), .id_mfhilo(id_mfhilo), .id_jump(id_jump),
        .stall(stall), .flush_if(flush_if), .FwdA(FwdA), .FwdB(FwdB),
        .mdu_start(mdu_start), .mdu_busy(mdu_busy), .stall_count(stall_count)
    );

    always #5 Clock = ~Clock;

    typedef struct packed {
        logic [4:0] rs, rt, rd;
        logic use_rs, use_rt, wreg, m2reg, mdu, mfhilo, jump;
    } instr_t;

    typedef struct packed {
        logic       wreg;
        logic       m2reg;
        logic [4:0] rd;
    } dst_t;

    int checks = 0;
    int failures = 0;

    // Reference model: writers in flight (index 0 = EXE, 1 = MEM), cycle the MDU result is ready.
    dst_t inflight[$];
    int   cyc = 0;
    int   mdu_free_at = 0;
    int   ref_stalls = 0;

    logic        obs_stall, obs_flush, obs_start, obs_busy;
    logic [1:0]  obs_fwda, obs_fwdb;
    logic [15:0] obs_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] ref_fwd(input logic use_src, input logic [4:0] r);
        if (!use_src || r == 5'd0) return 2'b00;
        if (inflight[0].wreg && !inflight[0].m2reg && inflight[0].rd == r) return 2'b01;
        if (inflight[1].wreg && inflight[1].rd == r) return inflight[1].m2reg ? 2'b11 : 2'b10;
        return 2'b00;
    endfunction

    task automatic run_cycle(input instr_t ins, input logic rst);
        logic busy, need_load, e_stall, e_flush, e_start;
        logic [1:0] e_fa, e_fb;
        dst_t d;
        Reset = rst;
        id_rs = ins.rs;  id_rt = ins.rt;  id_rd = ins.rd;
        id_use_rs = ins.use_rs;  id_use_rt = ins.use_rt;
        id_wreg = ins.wreg;  id_m2reg = ins.m2reg;
        id_mdu = ins.mdu;  id_mfhilo = ins.mfhilo;  id_jump = ins.jump;
        #2;
        busy = (cyc < mdu_free_at);
        need_load = inflight[0].wreg && inflight[0].m2reg && inflight[0].rd != 5'd0 &&
                    ((ins.use_rs && inflight[0].rd == ins.rs) || (ins.use_rt && inflight[0].rd == ins.rt));
        e_stall = !rst && (need_load || (busy && (ins.mdu || ins.mfhilo)));
        e_flush = !rst && ins.jump && !e_stall;
        e_start = !rst && ins.mdu && !e_stall;
        e_fa    = rst ? 2'b00 : ref_fwd(ins.use_rs, ins.rs);
        e_fb    = rst ? 2'b00 : ref_fwd(ins.use_rt, ins.rt);

        obs_stall = stall;  obs_flush = flush_if;  obs_start = mdu_start;  obs_busy = mdu_busy;
        obs_fwda = FwdA;  obs_fwdb = FwdB;  obs_cnt = stall_count;
        check("stall", stall, e_stall);
        check("flush_if", flush_if, e_flush);
        check("mdu_start", mdu_start, e_start);
        check("FwdA", FwdA, e_fa);
        check("FwdB", FwdB, e_fb);
        check("mdu_busy", mdu_busy, busy);
        check("stall_count", stall_count, ref_stalls);

        @(posedge Clock);
        if (rst) begin
            inflight.delete();
            inflight.push_back('0);
            inflight.push_back('0);
            mdu_free_at = 0;
            ref_stalls = 0;
        end else begin
            d = '0;
            if (!e_stall) begin
                d.wreg = ins.wreg;  d.m2reg = ins.m2reg;  d.rd = ins.rd;
            end
            inflight.push_front(d);
            void'(inflight.pop_back());
            if (e_start) mdu_free_at = cyc + LAT + 1;
            if (e_stall && ref_stalls < 65535) ref_stalls++;
        end
        cyc++;
        #1;
    endtask

    function automatic instr_t i_alu(input int rd, input int rs, input int rt);
        instr_t i = '0;
        i.rd = 5'(rd);  i.rs = 5'(rs);  i.rt = 5'(rt);
        i.use_rs = 1'b1;  i.use_rt = 1'b1;  i.wreg = 1'b1;
        return i;
    endfunction

    function automatic instr_t i_lw(input int rd, input int rs);
        instr_t i = '0;
        i.rd = 5'(rd);  i.rs = 5'(rs);
        i.use_rs = 1'b1;  i.wreg = 1'b1;  i.m2reg = 1'b1;
        return i;
    endfunction

    function automatic instr_t i_mult(input int rs, input int rt);
        instr_t i = '0;
        i.rs = 5'(rs);  i.rt = 5'(rt);
        i.use_rs = 1'b1;  i.use_rt = 1'b1;  i.mdu = 1'b1;
        return i;
    endfunction

    function automatic instr_t i_mflo(input int rd);
        instr_t i = '0;
        i.rd = 5'(rd);  i.wreg = 1'b1;  i.mfhilo = 1'b1;
        return i;
    endfunction

    function automatic instr_t rand_instr();
        instr_t i;
        int k;
        int rd, rs, rt;
        k  = int'($urandom_range(0, 9));
        rd = int'($urandom_range(0, 3));
        rs = int'($urandom_range(0, 3));
        rt = int'($urandom_range(0, 3));
        case (k)
            0, 1, 2, 3, 4: begin
                i = i_alu(rd, rs, rt);
                i.use_rt = ($urandom_range(0, 3) != 0);
            end
            5, 6:    i = i_lw(rd, rs);
            7:       i = i_mult(rs, rt);
            8:       i = i_mflo(rd);
            default: begin
                i = i_alu(0, rs, rt);
                i.wreg = 1'b0;
                i.jump = 1'b1;
            end
        endcase
        if ($urandom_range(0, 7) == 0) i.jump = 1'b1;
        return i;
    endfunction

    localparam instr_t NOP = '0;

    initial begin
        instr_t cur;
        repeat (2) @(posedge Clock);
        #1;
        inflight.push_back('0);
        inflight.push_back('0);

        // Reset state
        run_cycle(NOP, 1'b1);
        check("rst_cnt", obs_cnt, 16'd0);

        // EXE then MEM forwarding of an ALU result
        run_cycle(i_alu(1, 0, 0), 1'b0);
        run_cycle(i_alu(2, 1, 3), 1'b0);
        check("plan_fwd_exe", obs_fwda, 2'b01);
        check("plan_fwd_exe_nostall", obs_stall, 1'b0);
        run_cycle(i_alu(6, 1, 0), 1'b0);
        check("plan_fwd_mem", obs_fwda, 2'b10);

        // Load-use: one stall, then load data forwarded from MEM
        run_cycle(i_lw(4, 0), 1'b0);
        run_cycle(i_alu(5, 4, 4), 1'b0);
        check("plan_lu_stall", obs_stall, 1'b1);
        run_cycle(i_alu(5, 4, 4), 1'b0);
        check("plan_lu_release", obs_stall, 1'b0);
        check("plan_lu_fwda", obs_fwda, 2'b11);
        check("plan_lu_fwdb", obs_fwdb, 2'b11);
        check("plan_lu_cnt", obs_cnt, 16'd1);

        // Register $0 never matches
        run_cycle(i_alu(0, 1, 1), 1'b0);
        run_cycle(i_alu(7, 0, 0), 1'b0);
        check("plan_r0_fwd", obs_fwda, 2'b00);
        check("plan_r0_stall", obs_stall, 1'b0);
        run_cycle(i_lw(0, 2), 1'b0);
        run_cycle(i_alu(8, 0, 0), 1'b0);
        check("plan_r0_load_stall", obs_stall, 1'b0);

        // MDU busy window holds a dependent mflo for LAT cycles
        run_cycle(NOP, 1'b1);
        run_cycle(i_mult(1, 2), 1'b0);
        check("plan_mdu_start", obs_start, 1'b1);
        for (int i = 1; i <= LAT; i++) begin
            run_cycle(i_mflo(3), 1'b0);
            check("plan_mdu_wait", obs_stall, 1'b1);
            check("plan_mdu_busy", obs_busy, 1'b1);
        end
        run_cycle(i_mflo(3), 1'b0);
        check("plan_mdu_pass", obs_stall, 1'b0);
        check("plan_mdu_idle", obs_busy, 1'b0);
        check("plan_mdu_cnt", obs_cnt, 16'(LAT));

        // Jump under a load-use stall is deferred to the release cycle
        run_cycle(i_lw(4, 0), 1'b0);
        cur = i_alu(5, 4, 0);
        cur.jump = 1'b1;
        run_cycle(cur, 1'b0);
        check("plan_jmp_stall", obs_stall, 1'b1);
        check("plan_jmp_noflush", obs_flush, 1'b0);
        run_cycle(cur, 1'b0);
        check("plan_jmp_flush", obs_flush, 1'b1);

        // Reset in the middle of a busy window aborts it
        run_cycle(NOP, 1'b1);
        run_cycle(i_mult(1, 2), 1'b0);
        run_cycle(NOP, 1'b0);
        run_cycle(NOP, 1'b0);
        run_cycle(i_mflo(3), 1'b1);
        check("plan_rst_busy_before", obs_busy, 1'b1);
        check("plan_rst_forced", obs_stall, 1'b0);
        run_cycle(i_mflo(3), 1'b0);
        check("plan_rst_busy_after", obs_busy, 1'b0);
        check("plan_rst_stall_after", obs_stall, 1'b0);
        check("plan_rst_cnt", obs_cnt, 16'd0);

        // Random stream; a stalled instruction stays in ID until released
        cur = NOP;
        for (int n = 0; n < 3000; n++) begin
            if (!obs_stall) cur = rand_instr();
            run_cycle(cur, $urandom_range(0, 199) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage SCCPU. It sits beside the ID stage and tracks the destination registers of the instructions in EXE and MEM. From these it produces the forwarding selects FwdA/FwdB, the load-use and multiply/divide stall, and the IF flush for taken jumps and branches. It also sequences the shared multi-cycle multiply/divide unit (MDU) with a busy counter, so back-to-back MDU or HI/LO accesses wait for the result.

## Interface
- MDU_LATENCY, 8, cycles the MDU stays busy after a start pulse; legal range 1..255.
- Clock  in  1  rising-edge clock for all state.
- Reset  in  1  synchronous, active-high reset.
- id_rs, id_rt  in  5 each  source register numbers of the instruction in ID.
- id_use_rs, id_use_rt  in  1 each  the ID instruction actually reads rs / rt.
- id_rd  in  5  destination register of the ID instruction.
- id_wreg  in  1  the ID instruction writes the register file.
- id_m2reg  in  1  the ID instruction is a load.
- id_mdu  in  1  the ID instruction is mult/multu/div/divu.
- id_mfhilo  in  1  the ID instruction is mfhi/mflo/mthi/mtlo.
- id_jump  in  1  taken branch/jump resolved in ID (pcsource != 0).
- stall  out  1  freezes PC and IF/ID; ID/EXE loads a bubble.
- flush_if  out  1  replaces the fetched IF instruction with a nop.
- FwdA, FwdB  out  2 each  operand select: 00 regfile, 01 EXE ALU result, 10 MEM ALU result, 11 MEM load data.
- mdu_start  out  1  one-cycle start pulse to the MDU.
- mdu_busy  out  1  the MDU result is not yet available.
- stall_count  out  16  saturating count of stalled cycles since reset.

## Operation
- Shadow state: ex_wreg, ex_m2reg, ex_rd, mem_wreg, mem_m2reg, mem_rd.
  - Every cycle: mem_* <= ex_*.
  - ex_* <= id_* when stall=0. When stall=1, ex_* <= 0 (bubble).
- Writes to register 0 are ignored: a match requires rd != 0.
- Forwarding for rs (FwdA); rt (FwdB) is identical using id_rt/id_use_rt:
  - If use=0, the select is 00.
  - Otherwise, if ex_wreg & !ex_m2reg & ex_rd==rs, the select is 01 (EXE has priority over MEM).
  - Otherwise, if mem_wreg & mem_rd==rs, the select is 11 when mem_m2reg, else 10.
  - Otherwise, the select is 00.
- load_stall = ex_wreg & ex_m2reg & ex_rd!=0 & ((id_use_rs & ex_rd==id_rs) | (id_use_rt & ex_rd==id_rt)).
- mdu_stall = mdu_busy & (id_mdu | id_mfhilo).
- stall = load_stall | mdu_stall.
- flush_if = id_jump & !stall; a stalled jump takes effect when it is released.
- mdu_start = id_mdu & !stall.
- MDU counter (8-bit cnt):
  - mdu_start loads cnt with MDU_LATENCY.
  - Otherwise cnt decrements while nonzero.
  - mdu_busy = (cnt != 0).
- stall_count increments on each cycle with stall=1 and holds at 0xFFFF.

## Timing
- stall, flush_if, FwdA/B and mdu_start are combinational from the current ID inputs and the registered state, valid in the same cycle.
- A load in EXE that feeds ID causes exactly one stall cycle. The next cycle the load is in MEM and the select is 11.
- mdu_start in cycle t makes mdu_busy=1 in cycles t+1 .. t+MDU_LATENCY. A dependent MDU or HI/LO instruction in ID proceeds in cycle t+MDU_LATENCY+1.
- When load_stall and mdu_stall occur together, a single stall is asserted and each condition clears independently.
- Reset at the edge clears all shadow state, cnt and stall_count. While Reset=1, stall, flush_if and mdu_start are forced to 0 and FwdA/FwdB to 00. A reset during MDU busy aborts the busy window (mdu_busy=0 after the edge).
- Reset values of all outputs: 0.

## Test plan
- add $1 in EXE, then ID `sub $2,$1,$3` -> FwdA=01, stall=0. One instruction later (add in MEM) -> FwdA=10.
- lw $4 in EXE, ID `add $5,$4,$4` -> stall=1 for exactly 1 cycle, ex bubble. Then FwdA=FwdB=11, stall=0; stall_count=1.
- ID writes/reads $0 with EXE add $0 -> FwdA=00, no stall.
- MDU_LATENCY=8, mult issued at t -> mdu_start=1 at t. A following mflo in ID at t+1 stalls cycles t+1..t+8 and passes at t+9; stall_count=8.
- Load-use stall coincident with id_jump=1 -> flush_if=0 during the stall, flush_if=1 in the release cycle.
- Reset asserted at t+3 of an MDU busy window -> mdu_busy=0 and stall=0 the next cycle, stall_count=0.
